mmio_bridge: RTL and testbench

Parametrised memory/IO bridge between the SLC-3 datapath (MAR/MDR side) and the external SRAM plus board I/O.
- Replaces the fixed single-cycle memory subsystem.
- Adds a req/ack handshake, configurable SRAM wait states, configurable hex digit and switch counts, and a readable display register.
- Sits between the datapath/ISDU and the SRAM pins and HexDriver array.

---
 rtl/slc3_pkg.sv | 19 +
 rtl/mmio_wait_counter.sv | 25 ++
 rtl/mmio_bridge.sv | 136 +++++++++++++
 tb/tb_mmio_bridge.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_pkg.sv
// Shared SLC-3 memory/IO definitions: bridge FSM states, IO address offsets
// and default bus widths.
package slc3_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IO,
        SRAM,
        ACK
    } bridge_state_t;

    // Offsets below IO_BASE: switches/display write at +0, display readback at -1
    localparam int IO_SW_OFFSET    = 0;
    localparam int IO_HEXRB_OFFSET = 1;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;

endpackage

// File: rtl/mmio_wait_counter.sv
// Loadable 4-bit down-counter that times SRAM strobe cycles; saturates at 0.
module mmio_wait_counter (
    input  logic       clk,
    input  logic       srst,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] load_val,
    output logic       done
);

    logic [3:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != 4'd0)) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign done = (count_reg == 4'd0);

endmodule

// File: rtl/mmio_bridge.sv
// Memory/IO bridge between the SLC-3 MAR/MDR side and external SRAM plus
// board switches and hex display, with req/ack handshake and SRAM wait states.
module mmio_bridge
    import slc3_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                N_HEX    = 4,
    parameter int                SW_W     = 10,
    parameter int                WAIT_CYC = 1,
    parameter logic [ADDR_W-1:0] IO_BASE  = {ADDR_W{1'b1}}
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata,
    output logic                 ack,
    output logic                 busy,
    input  logic [SW_W-1:0]      Switches,
    output logic [4*N_HEX-1:0]   Hex_out,
    output logic [ADDR_W-1:0]    SRAM_ADDR,
    input  logic [DATA_W-1:0]    Data_from_SRAM,
    output logic [DATA_W-1:0]    Data_to_SRAM,
    output logic                 OE_N,
    output logic                 WE_N
);

    localparam int                HEX_W      = 4 * N_HEX;
    localparam logic [ADDR_W-1:0] SW_ADDR    = IO_BASE - ADDR_W'(IO_SW_OFFSET);
    localparam logic [ADDR_W-1:0] HEXRB_ADDR = IO_BASE - ADDR_W'(IO_HEXRB_OFFSET);

    bridge_state_t       state_reg, state_next;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [HEX_W-1:0]    wdata_hex_reg;
    logic [HEX_W-1:0]    hex_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic [ADDR_W-1:0]   sram_addr_reg;
    logic [DATA_W-1:0]   to_sram_reg;
    logic                oe_n_reg, we_n_reg;

    logic                accept;
    logic                addr_is_io;
    logic                cnt_done;
    logic [DATA_W-1:0]   sw_ext, hex_ext;

    assign accept     = (state_reg == IDLE) && req;
    assign addr_is_io = (addr == SW_ADDR) || (addr == HEXRB_ADDR);

    always_comb begin
        sw_ext              = '0;
        sw_ext[SW_W-1:0]    = Switches;
        hex_ext             = '0;
        hex_ext[HEX_W-1:0]  = hex_reg;
    end

    mmio_wait_counter u_wait (
        .clk      (Clk),
        .srst     (Reset),
        .load     (accept),
        .en       (state_reg == SRAM),
        .load_val (4'(WAIT_CYC)),
        .done     (cnt_done)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req) state_next = addr_is_io ? IO : SRAM;
            IO:      state_next = ACK;
            SRAM:    if (cnt_done) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_hex_reg <= '0;
            hex_reg       <= '0;
            rdata_reg     <= '0;
            sram_addr_reg <= '0;
            to_sram_reg   <= '0;
            oe_n_reg      <= 1'b1;
            we_n_reg      <= 1'b1;
        end else begin
            if (accept) begin
                we_reg        <= we;
                addr_reg      <= addr;
                wdata_hex_reg <= wdata[HEX_W-1:0];
                if (!addr_is_io) begin
                    sram_addr_reg <= addr;
                    to_sram_reg   <= wdata;
                    oe_n_reg      <= we;
                    we_n_reg      <= !we;
                end
            end
            // Writes to the readback address fall through here and change nothing
            if (state_reg == IO) begin
                if (we_reg) begin
                    if (addr_reg == SW_ADDR) hex_reg <= wdata_hex_reg;
                end else begin
                    rdata_reg <= (addr_reg == SW_ADDR) ? sw_ext : hex_ext;
                end
            end
            if ((state_reg == SRAM) && cnt_done) begin
                oe_n_reg <= 1'b1;
                we_n_reg <= 1'b1;
                if (!we_reg) rdata_reg <= Data_from_SRAM;
            end
        end
    end

    assign rdata        = rdata_reg;
    assign ack          = (state_reg == ACK);
    assign busy         = (state_reg != IDLE);
    assign Hex_out      = hex_reg;
    assign SRAM_ADDR    = sram_addr_reg;
    assign Data_to_SRAM = to_sram_reg;
    assign OE_N         = oe_n_reg;
    assign WE_N         = we_n_reg;

endmodule

// File: tb/tb_mmio_bridge.sv
// Bench for mmio_bridge: three instances (WAIT_CYC 0/2/3) share one stimulus
// stream and are checked every cycle against a transaction-level timing model.
module tb_mmio_bridge;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [9:0]  sw = '0;

    logic [15:0] rdata_a [NI];
    logic [15:0] sram_addr_a [NI];
    logic [15:0] dfs_a [NI];
    logic [15:0] dts_a [NI];
    logic [15:0] hex_a [NI];
    logic        ack_a [NI];
    logic        busy_a [NI];
    logic        oe_n_a [NI];
    logic        we_n_a [NI];

    logic [15:0] mem [NI][256];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function automatic int wait_of(int k);
        case (k)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [15:0] mem_init(int a);
        return {8'hC3, a[7:0]};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            localparam int W = (gi == 0) ? 0 : ((gi == 1) ? 2 : 3);
            mmio_bridge #(
                .DATA_W   (16),
                .ADDR_W   (16),
                .N_HEX    (4),
                .SW_W     (10),
                .WAIT_CYC (W),
                .IO_BASE  (16'hFFFF)
            ) dut (
                .Clk            (clk),
                .Reset          (rst),
                .req            (req),
                .we             (we),
                .addr           (addr),
                .wdata          (wdata),
                .rdata          (rdata_a[gi]),
                .ack            (ack_a[gi]),
                .busy           (busy_a[gi]),
                .Switches       (sw),
                .Hex_out        (hex_a[gi]),
                .SRAM_ADDR      (sram_addr_a[gi]),
                .Data_from_SRAM (dfs_a[gi]),
                .Data_to_SRAM   (dts_a[gi]),
                .OE_N           (oe_n_a[gi]),
                .WE_N           (we_n_a[gi])
            );
            assign dfs_a[gi] = mem[gi][sram_addr_a[gi][7:0]];
        end
    endgenerate

    // Asynchronous-SRAM stand-in: a write lands on every edge that sees WE_N low
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (we_n_a[k] == 1'b0) mem[k][sram_addr_a[k][7:0]] <= dts_a[k];
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: t counts cycles since acceptance (1 = first cycle after
    // the accepting edge); ack lands at t==lat, strobes cover t=1..WAIT+1.
    bit          m_ready = 1'b0;
    bit          m_act [NI];
    int          m_t [NI];
    int          m_lat [NI];
    bit          m_io [NI];
    bit          m_we [NI];
    logic [15:0] m_addr [NI];
    logic [15:0] m_wd [NI];
    logic [15:0] m_hex [NI];
    logic [15:0] m_rd [NI];
    logic [15:0] m_mem [NI][256];
    bit          m_acc;

    always @(posedge clk) begin
        if (rst) begin
            m_ready = 1'b1;
            for (int k = 0; k < NI; k++) begin
                m_act[k] = 1'b0;
                m_hex[k] = '0;
                m_rd[k]  = '0;
            end
        end else if (m_ready) begin
            for (int k = 0; k < NI; k++) begin
                m_acc = !m_act[k] && req;
                if (m_act[k]) begin
                    m_t[k]++;
                    if (m_t[k] > m_lat[k]) m_act[k] = 1'b0;
                end
                if (m_acc) begin
                    m_act[k]  = 1'b1;
                    m_t[k]    = 1;
                    m_we[k]   = we;
                    m_addr[k] = addr;
                    m_wd[k]   = wdata;
                    m_io[k]   = (addr == 16'hFFFF) || (addr == 16'hFFFE);
                    m_lat[k]  = m_io[k] ? 2 : wait_of(k) + 2;
                    if (!m_io[k] && we) m_mem[k][addr[7:0]] = wdata;
                end else if (m_act[k]) begin
                    if (m_io[k] && m_t[k] == 2 && m_we[k] && m_addr[k] == 16'hFFFF)
                        m_hex[k] = m_wd[k];
                    if (m_t[k] == m_lat[k] && !m_we[k]) begin
                        if (m_io[k])
                            m_rd[k] = (m_addr[k] == 16'hFFFF) ? {6'b0, sw} : m_hex[k];
                        else
                            m_rd[k] = m_mem[k][m_addr[k][7:0]];
                    end
                end
            end
        end
    end

    bit cmp_strobe;
    bit cmp_ack;

    always @(negedge clk) begin
        if (m_ready) begin
            for (int k = 0; k < NI; k++) begin
                cmp_strobe = m_act[k] && !m_io[k] && (m_t[k] <= wait_of(k) + 1);
                cmp_ack    = m_act[k] && (m_t[k] == m_lat[k]);
                check($sformatf("busy%0d", k), 16'(busy_a[k]), 16'(m_act[k]));
                check($sformatf("ack%0d", k), 16'(ack_a[k]), 16'(cmp_ack));
                check($sformatf("oe_n%0d", k), 16'(oe_n_a[k]), 16'(!(cmp_strobe && !m_we[k])));
                check($sformatf("we_n%0d", k), 16'(we_n_a[k]), 16'(!(cmp_strobe && m_we[k])));
                check($sformatf("hex%0d", k), hex_a[k], m_hex[k]);
                if (cmp_strobe) begin
                    check($sformatf("sram_addr%0d", k), sram_addr_a[k], m_addr[k]);
                    if (m_we[k]) check($sformatf("to_sram%0d", k), dts_a[k], m_wd[k]);
                end
                if (cmp_ack) check($sformatf("rdata%0d", k), rdata_a[k], m_rd[k]);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy_a[0] || busy_a[1] || busy_a[2]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 16'(n < 50), 16'd1);
    endtask

    task automatic do_txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input int k, output int ack_c, output int strb,
                          output logic [15:0] rd);
        wait_idle();
        req = 1'b1; we = w; addr = a; wdata = d;
        ack_c = -1; strb = 0; rd = '0;
        for (int c = 1; c <= 30 && ack_c < 0; c++) begin
            @(negedge clk);
            if (c == 1) req = 1'b0;
            if (!oe_n_a[k] || !we_n_a[k]) strb++;
            if (ack_a[k]) begin
                ack_c = c;
                rd = rdata_a[k];
            end
        end
        check("ack_seen", 16'(ack_c > 0), 16'd1);
        $display("txn inst%0d we=%0b addr=%h wdata=%h -> ack_cycle=%0d strobes=%0d rdata=%h",
                 k, w, a, d, ack_c, strb, rd);
    endtask

    int          ack_c, strb, acks, ack1_c, ack2_c;
    logic [15:0] rd, rd1, rd2;

    initial begin
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < 256; i++) begin
                mem[k][i]   = mem_init(i);
                m_mem[k][i] = mem_init(i);
            end

        repeat (3) @(negedge clk);
        check("rst_busy", 16'(busy_a[0]), 16'd0);
        check("rst_oe_n", 16'(oe_n_a[0]), 16'd1);
        check("rst_we_n", 16'(we_n_a[0]), 16'd1);
        check("rst_hex", hex_a[0], 16'h0000);
        rst = 1'b0;

        // Switch read
        sw = 10'h2A5;
        do_txn(1'b0, 16'hFFFF, 16'h0000, 0, ack_c, strb, rd);
        check("sw_lat", 16'(ack_c), 16'd2);
        check("sw_rdata", rd, 16'h02A5);
        check("sw_no_oe", 16'(strb), 16'd0);

        // Display write then readback
        do_txn(1'b1, 16'hFFFF, 16'hBEEF, 0, ack_c, strb, rd);
        check("hex_lat", 16'(ack_c), 16'd2);
        for (int k = 0; k < NI; k++) check("hex_val", hex_a[k], 16'hBEEF);
        do_txn(1'b0, 16'hFFFE, 16'h0000, 0, ack_c, strb, rd);
        check("hexrb_rdata", rd, 16'hBEEF);

        // SRAM write then read on the WAIT_CYC=2 instance
        do_txn(1'b1, 16'h0040, 16'h1234, 1, ack_c, strb, rd);
        check("sram_wr_lat", 16'(ack_c), 16'd4);
        check("sram_wr_strobes", 16'(strb), 16'd3);
        do_txn(1'b0, 16'h0040, 16'h0000, 1, ack_c, strb, rd);
        check("sram_rd_lat", 16'(ack_c), 16'd4);
        check("sram_rd_strobes", 16'(strb), 16'd3);
        check("sram_rd_data", rd, 16'h1234);

        // Request while busy is dropped, not queued
        wait_idle();
        req = 1'b1; we = 1'b0; addr = 16'h0040;
        acks = 0; strb = 0; rd = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (!oe_n_a[1]) strb++;
            if (ack_a[1]) begin acks++; rd = rdata_a[1]; end
            if (c == 1) addr = 16'h0010;
            if (c == 3) req = 1'b0;
        end
        $display("busy-ignore inst1: acks=%0d strobes=%0d rdata=%h", acks, strb, rd);
        check("busy_acks", 16'(acks), 16'd1);
        check("busy_strobes", 16'(strb), 16'd3);
        check("busy_rdata", rd, 16'h1234);

        // Back-to-back reads with req held high, WAIT_CYC=0 instance
        wait_idle();
        req = 1'b1; we = 1'b0; addr = 16'h0001;
        ack1_c = -1; ack2_c = -1; rd1 = '0; rd2 = '0; strb = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (!oe_n_a[0]) strb++;
            if (ack_a[0]) begin
                if (ack1_c < 0) begin ack1_c = c; rd1 = rdata_a[0]; end
                else begin ack2_c = c; rd2 = rdata_a[0]; end
            end
            if (c == 1) addr = 16'h0002;
            if (c == 4) req = 1'b0;
        end
        $display("b2b inst0: ack cycles %0d,%0d rdata %h,%h strobes=%0d", ack1_c, ack2_c, rd1, rd2, strb);
        check("b2b_ack1", 16'(ack1_c), 16'd2);
        check("b2b_ack2", 16'(ack2_c), 16'd5);
        check("b2b_rd1", rd1, 16'hC301);
        check("b2b_rd2", rd2, 16'hC302);
        check("b2b_strobes", 16'(strb), 16'd2);

        // Reset during an SRAM read on the WAIT_CYC=3 instance
        wait_idle();
        req = 1'b1; we = 1'b0; addr = 16'h0040;
        acks = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ack_a[2]) acks++;
            if (c == 1) begin
                check("mid_oe_active", 16'(oe_n_a[2]), 16'd0);
                req = 1'b0;
                rst = 1'b1;
            end
            if (c == 2) begin
                check("rst_oe_off", 16'(oe_n_a[2]), 16'd1);
                check("rst_we_off", 16'(we_n_a[2]), 16'd1);
                check("rst_busy2", 16'(busy_a[2]), 16'd0);
                check("rst_hex2", hex_a[2], 16'h0000);
            end
            if (c == 3) rst = 1'b0;
        end
        $display("reset-abort inst2: acks=%0d", acks);
        check("rst_no_ack", 16'(acks), 16'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
